datapath: RTL and testbench
===========================

# datapath

Single-bus 32-bit CPU datapath for the course processor: sixteen general registers, special registers (PC, IR, MAR, MDR, Y, HI, LO, 64-bit Z), a shared bus multiplexer and a combinational ALU. All sequencing comes from externally driven control strobes; the block contains no control unit. Debug "view" outputs expose internal state for simulation.

## Interface
- No parameters; data width fixed at 32 bits.
- clk  in  1  rising-edge clock for every register.
- clr  in  1  asynchronous, active-low reset; clears every register to 0.
- R_rd  in  16  per-register load enables, bit n loads Rn from bus.
- R_wrt  in  16  per-register bus-drive selects, bit n drives Rn.
- HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out  in  1 each  bus-drive selects.
- MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd  in  1 each  register load enables.
- IncPC  in  1  increment PC.
- Read  in  1  MDR input select: 1 selects Mdatain, 0 selects bus.
- op_sel  in  5  ALU operation code.
- Mdatain  in  32  memory read data.
- r3_view, r4_view, r7_view, Y_view, Zlo_view, MDR_view, PC_view  out  32  live register contents.
- BusMuxOut  out  32  current bus value.
- Data_view  out  32  MDR input mux output.

## Operation
- Registers: R0–R15, HI, LO, PC, IR, MAR, MDR, Y are 32-bit; Z is 64-bit (Zhi, Zlo). Each loads on the rising clk edge when its enable is high and otherwise holds.
- Bus: combinational. Among asserted selects, the first in this priority order drives the bus: R0..R15, HI, LO, Zhi, Zlo, PC, MDR, MAR, In, C. With no select asserted the bus is 0.
- In_out drives 0; the input port is not wired at this level.
- C_out drives IR[18:0] sign-extended to 32 bits.
- MDR input: Read ? Mdatain : BusMuxOut. Data_view shows this value. MDR loads it when MDR_rd=1.
- ALU: A=Y, B=BusMuxOut, combinational. Zlo_rd loads the full 64-bit result into Z.
- ALU op codes. For every code except mul/div, Zhi=0 and Zlo is the result:
  - 00011 add: A+B, mod 2^32.
  - 00100 sub: A−B, mod 2^32.
  - 00101 and. 00110 or.
  - 00111 ror: rotate A right by B[4:0]. 01000 rol: rotate A left by B[4:0].
  - 01001 shr: logical shift right by B[4:0]. 01010 shra: arithmetic shift right by B[4:0]. 01011 shl: shift left by B[4:0].
  - 01111 mul: signed A×B, full 64-bit product into {Zhi,Zlo}.
  - 10000 div: signed; Zlo = quotient, Zhi = remainder. Divide by zero gives Z = 0.
  - 10001 neg: −B. 10010 not: ~B.
  - Any other code passes B through.
- PC: PC_rd=1 loads the bus. Otherwise IncPC=1 gives PC+1, wrapping 0xFFFFFFFF to 0. PC_rd wins when both are asserted.
- R0 is an ordinary register, not hardwired to zero.

## Timing
- clr low: all registers, and therefore all views, read 0 immediately and asynchronously. Loads are ignored while clr is low. Normal operation resumes at the first rising edge after clr returns high.
- Load latency: 1 edge. A value driven on the bus before edge k is visible on the view outputs after edge k.
- BusMuxOut, Data_view and the ALU result are combinational with zero-cycle latency.
- A register may drive the bus and load from it in the same cycle; it captures the pre-edge bus value.
- An ALU operation takes one cycle per transfer step: load Y, then compute into Z, then write Z to a register.

## Test plan
- Reset: hold clr=0 with any enables asserted → every view is 0. Release clr=1 → the first edge loads normally.
- Register load: Mdatain=0x17, Read=1, MDR_rd=1, edge → MDR_view=0x17, Data_view=0x17. Then MDR_out=1, R_rd[3]=1, edge → r3_view=0x17. Repeat with R4=0x14 and R7=0x50.
- Add sequence:
  - IR ← 0x19A38000 via MDR.
  - R_wrt[3]+Y_rd → Y_view=0x17.
  - R_wrt[7]+op_sel=00011+Zlo_rd → Zlo_view=0x67.
  - Zlo_out+R_rd[4] → r4_view=0x67.
- PC: MDR=7 driven on the bus with PC_rd=1 → PC_view=7. IncPC pulse → 8. PC=0xFFFFFFFF with IncPC → 0. PC_rd and IncPC together → bus value.
- ALU corners:
  - sub 0x14−0x17 → Zlo=0xFFFFFFFD.
  - mul (−2)×3 → Zhi=0xFFFFFFFF, Zlo=0xFFFFFFFA.
  - div 7/2 → Zlo=3, Zhi=1.
  - div by 0 → Z=0.
  - shra 0x80000000 by 4 → 0xF8000000.
- Bus priority: R_wrt[3] and MDR_out both set → bus = R3. No select asserted → bus 0. C_out with IR[18]=1 → upper 13 bits are all 1.

Source files
------------

// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
//   Single-bus 32-bit CPU datapath: sixteen general registers R0..R15, special
//   registers PC, IR, MAR, MDR, Y, HI, LO and a 64-bit Z, one shared bus driven
//   through a priority multiplexer, and a combinational ALU (A = Y, B = bus).
//   Every transfer is steered by externally driven strobes; no control unit.
//
// Ports
//   clk                rising-edge clock for every register
//   clr                asynchronous active-low clear of every register
//   R_rd / R_wrt       per-register load enables / bus-drive selects (bit n = Rn)
//   *_out              bus-drive selects (HI, LO, Zhi, Zlo, PC, MDR, MAR, In, C)
//   *_rd               load enables (MAR, Z, PC, MDR, IR, Y)
//   IncPC              PC <= PC + 1 when PC is not being loaded from the bus
//   Read               MDR source: 1 = Mdatain, 0 = bus
//   op_sel             ALU operation code
//   Mdatain            memory read data
//   *_view             live register contents for debug
//   BusMuxOut          current bus value
//   Data_view          MDR input mux output
// -----------------------------------------------------------------------------
module datapath (
   input  logic        clk,
   input  logic        clr,
   input  logic [15:0] R_rd,
   input  logic [15:0] R_wrt,
   input  logic        HI_out,
   input  logic        LO_out,
   input  logic        Zhi_out,
   input  logic        Zlo_out,
   input  logic        PC_out,
   input  logic        MDR_out,
   input  logic        MAR_out,
   input  logic        In_out,
   input  logic        C_out,
   input  logic        MAR_rd,
   input  logic        Zlo_rd,
   input  logic        PC_rd,
   input  logic        MDR_rd,
   input  logic        IR_rd,
   input  logic        Y_rd,
   input  logic        IncPC,
   input  logic        Read,
   input  logic [4:0]  op_sel,
   input  logic [31:0] Mdatain,
   output logic [31:0] r3_view,
   output logic [31:0] r4_view,
   output logic [31:0] r7_view,
   output logic [31:0] Y_view,
   output logic [31:0] Zlo_view,
   output logic [31:0] MDR_view,
   output logic [31:0] PC_view,
   output logic [31:0] BusMuxOut,
   output logic [31:0] Data_view
);

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   logic [31:0] gpr_r [16];
   logic [31:0] hi_r, lo_r, pc_r, mar_r, mdr_r, y_r;
   // Only IR[18:0] has a consumer here (the C sign-extension path), so only
   // those bits are stored.
   logic [18:0] ir_r;
   logic [63:0] z_r;

   logic [31:0] bus_s, mdr_in_s, c_ext_s;
   logic [4:0]  sh_s;
   logic [5:0]  rot_back_s;
   logic [63:0] prod_s;
   logic [31:0] quo_s, rem_s;
   logic [63:0] alu_s;

   assign c_ext_s    = {{13{ir_r[18]}}, ir_r};
   assign sh_s       = bus_s[4:0];
   assign rot_back_s = 6'd32 - {1'b0, sh_s};
   assign prod_s     = $signed({{32{y_r[31]}}, y_r}) * $signed({{32{bus_s[31]}}, bus_s});
   assign mdr_in_s   = Read ? Mdatain : bus_s;

   // Bus multiplexer: lowest-numbered Rn wins, then the fixed special order
   always_comb begin
      bus_s = 32'd0;
      if (R_wrt != 16'd0) begin
         // Walk downward so the lowest set select is the last to assign
         for (int i = 15; i >= 0; i--) begin
            bus_s = R_wrt[i] ? gpr_r[i] : bus_s;
         end
      end else if (HI_out) begin
         bus_s = hi_r;
      end else if (LO_out) begin
         bus_s = lo_r;
      end else if (Zhi_out) begin
         bus_s = z_r[63:32];
      end else if (Zlo_out) begin
         bus_s = z_r[31:0];
      end else if (PC_out) begin
         bus_s = pc_r;
      end else if (MDR_out) begin
         bus_s = mdr_r;
      end else if (MAR_out) begin
         bus_s = mar_r;
      end else if (In_out) begin
         bus_s = 32'd0;  // input port is not wired at this level
      end else if (C_out) begin
         bus_s = c_ext_s;
      end else begin
         bus_s = 32'd0;
      end
   end

   // Signed divide; a zero divisor yields a zero quotient and remainder
   always_comb begin
      quo_s = 32'd0;
      rem_s = 32'd0;
      if (bus_s == 32'd0) begin
         quo_s = 32'd0;
         rem_s = 32'd0;
      end else begin
         quo_s = $signed(y_r) / $signed(bus_s);
         rem_s = $signed(y_r) % $signed(bus_s);
      end
   end

   // ALU result, 64 bits wide; upper half is zero except for mul and div
   always_comb begin
      alu_s = {32'd0, bus_s};
      case (op_sel)
         OP_ADD:  alu_s = {32'd0, y_r + bus_s};
         OP_SUB:  alu_s = {32'd0, y_r - bus_s};
         OP_AND:  alu_s = {32'd0, y_r & bus_s};
         OP_OR:   alu_s = {32'd0, y_r | bus_s};
         // A shift by 32 yields 0, so a zero rotate amount falls out naturally
         OP_ROR:  alu_s = {32'd0, (y_r >> sh_s) | (y_r << rot_back_s)};
         OP_ROL:  alu_s = {32'd0, (y_r << sh_s) | (y_r >> rot_back_s)};
         OP_SHR:  alu_s = {32'd0, y_r >> sh_s};
         OP_SHRA: alu_s = {32'd0, 32'($signed(y_r) >>> sh_s)};
         OP_SHL:  alu_s = {32'd0, y_r << sh_s};
         OP_MUL:  alu_s = prod_s;
         OP_DIV:  alu_s = {rem_s, quo_s};
         OP_NEG:  alu_s = {32'd0, 32'd0 - bus_s};
         OP_NOT:  alu_s = {32'd0, ~bus_s};
         default: alu_s = {32'd0, bus_s};
      endcase
   end

   // Register file and special registers: async clear, per-register load
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < 16; i++) begin
            gpr_r[i] <= 32'd0;
         end
         hi_r  <= 32'd0;
         lo_r  <= 32'd0;
         pc_r  <= 32'd0;
         ir_r  <= 19'd0;
         mar_r <= 32'd0;
         mdr_r <= 32'd0;
         y_r   <= 32'd0;
         z_r   <= 64'd0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (R_rd[i]) begin
               gpr_r[i] <= bus_s;
            end else begin
               gpr_r[i] <= gpr_r[i];
            end
         end
         // HI and LO have no load strobe at this level; they hold their value
         hi_r <= hi_r;
         lo_r <= lo_r;
         if (PC_rd) begin
            pc_r <= bus_s;
         end else if (IncPC) begin
            pc_r <= pc_r + 32'd1;
         end else begin
            pc_r <= pc_r;
         end
         ir_r  <= IR_rd  ? bus_s[18:0] : ir_r;
         mar_r <= MAR_rd ? bus_s       : mar_r;
         mdr_r <= MDR_rd ? mdr_in_s    : mdr_r;
         y_r   <= Y_rd   ? bus_s       : y_r;
         z_r   <= Zlo_rd ? alu_s       : z_r;
      end
   end

   assign r3_view   = gpr_r[3];
   assign r4_view   = gpr_r[4];
   assign r7_view   = gpr_r[7];
   assign Y_view    = y_r;
   assign Zlo_view  = z_r[31:0];
   assign MDR_view  = mdr_r;
   assign PC_view   = pc_r;
   assign BusMuxOut = bus_s;
   assign Data_view = mdr_in_s;

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath
//   Self-checking bench for datapath: directed transfer sequences with fixed
//   expected values, then randomized strobes checked against a behavioural
//   model of the register transfers and ALU arithmetic.
// -----------------------------------------------------------------------------
module tb_datapath;

   logic        clk = 1'b0;
   logic        clr;
   logic [15:0] R_rd, R_wrt;
   logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
   logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, IncPC, Read;
   logic [4:0]  op_sel;
   logic [31:0] Mdatain;
   logic [31:0] r3_view, r4_view, r7_view, Y_view, Zlo_view, MDR_view, PC_view;
   logic [31:0] BusMuxOut, Data_view;

   datapath dut (
      .clk(clk), .clr(clr), .R_rd(R_rd), .R_wrt(R_wrt),
      .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
      .PC_out(PC_out), .MDR_out(MDR_out), .MAR_out(MAR_out), .In_out(In_out),
      .C_out(C_out), .MAR_rd(MAR_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd),
      .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd), .IncPC(IncPC), .Read(Read),
      .op_sel(op_sel), .Mdatain(Mdatain),
      .r3_view(r3_view), .r4_view(r4_view), .r7_view(r7_view), .Y_view(Y_view),
      .Zlo_view(Zlo_view), .MDR_view(MDR_view), .PC_view(PC_view),
      .BusMuxOut(BusMuxOut), .Data_view(Data_view)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state
   logic [31:0] m_r [16];
   logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y;
   logic [63:0] m_z;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
      m_hi = 32'd0; m_lo = 32'd0; m_pc = 32'd0; m_ir = 32'd0;
      m_mar = 32'd0; m_mdr = 32'd0; m_y = 32'd0; m_z = 64'd0;
   endtask

   task automatic clear_ctrl();
      R_rd = 16'd0; R_wrt = 16'd0;
      HI_out = 1'b0; LO_out = 1'b0; Zhi_out = 1'b0; Zlo_out = 1'b0; PC_out = 1'b0;
      MDR_out = 1'b0; MAR_out = 1'b0; In_out = 1'b0; C_out = 1'b0;
      MAR_rd = 1'b0; Zlo_rd = 1'b0; PC_rd = 1'b0; MDR_rd = 1'b0; IR_rd = 1'b0;
      Y_rd = 1'b0; IncPC = 1'b0; Read = 1'b0; op_sel = 5'd0;
   endtask

   // Bus value from the priority list
   function automatic logic [31:0] m_bus();
      int unsigned c;
      for (int i = 0; i < 16; i++) if (R_wrt[i]) return m_r[i];
      if (HI_out)  return m_hi;
      if (LO_out)  return m_lo;
      if (Zhi_out) return m_z[63:32];
      if (Zlo_out) return m_z[31:0];
      if (PC_out)  return m_pc;
      if (MDR_out) return m_mdr;
      if (MAR_out) return m_mar;
      if (In_out)  return 32'd0;
      if (C_out) begin
         c = m_ir % 32'h80000;                  // 19-bit field
         if (c >= 32'h40000) c = c + 32'hFFF80000; // negative: fill upper bits
         return c;
      end
      return 32'd0;
   endfunction

   function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
      int unsigned n;
      logic [31:0] x;
      int sa, sb, q, r;
      longint p;
      n = b % 32; x = a; sa = a; sb = b;
      case (op)
         5'd3:  return {32'd0, a + b};
         5'd4:  return {32'd0, a - b};
         5'd5:  return {32'd0, a & b};
         5'd6:  return {32'd0, a | b};
         5'd7:  begin for (int k = 0; k < n; k++) x = {x[0], x[31:1]}; return {32'd0, x}; end
         5'd8:  begin for (int k = 0; k < n; k++) x = {x[30:0], x[31]}; return {32'd0, x}; end
         5'd9:  return {32'd0, a >> n};
         5'd10: begin for (int k = 0; k < n; k++) x = {x[31], x[31:1]}; return {32'd0, x}; end
         5'd11: return {32'd0, a << n};
         5'd15: begin p = longint'(sa) * longint'(sb); return p; end
         5'd16: begin
            if (b == 32'd0) return 64'd0;
            q = sa / sb; r = sa % sb;
            return {r, q};
         end
         5'd17: return {32'd0, 32'd0 - b};
         5'd18: return {32'd0, ~b};
         default: return {32'd0, b};
      endcase
   endfunction

   task automatic check_views();
      check_eq("r3_view",  r3_view,  m_r[3]);
      check_eq("r4_view",  r4_view,  m_r[4]);
      check_eq("r7_view",  r7_view,  m_r[7]);
      check_eq("y_view",   Y_view,   m_y);
      check_eq("zlo_view", Zlo_view, m_z[31:0]);
      check_eq("mdr_view", MDR_view, m_mdr);
      check_eq("pc_view",  PC_view,  m_pc);
   endtask

   // One transfer step: check bus/MDR mux mid-cycle, advance model, check views
   task automatic tick();
      logic [31:0] b, d;
      logic [63:0] z;
      @(negedge clk);
      b = m_bus();
      d = Read ? Mdatain : b;
      z = m_alu(m_y, b, op_sel);
      check_eq("bus", BusMuxOut, b);
      check_eq("data_view", Data_view, d);
      for (int i = 0; i < 16; i++) if (R_rd[i]) m_r[i] = b;
      if (MAR_rd) m_mar = b;
      if (IR_rd)  m_ir  = b;
      if (Y_rd)   m_y   = b;
      if (MDR_rd) m_mdr = d;
      if (Zlo_rd) m_z   = z;
      if (PC_rd) m_pc = b;
      else if (IncPC) m_pc = m_pc + 32'd1;
      @(posedge clk); #1;
      check_views();
   endtask

   task automatic load_mdr(input logic [31:0] v);
      clear_ctrl(); Mdatain = v; Read = 1'b1; MDR_rd = 1'b1; tick(); clear_ctrl();
   endtask

   task automatic mdr_to_reg(input int n);
      clear_ctrl(); MDR_out = 1'b1; R_rd[n] = 1'b1; tick(); clear_ctrl();
   endtask

   task automatic alu_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] op, input logic [31:0] ehi, input logic [31:0] elo);
      load_mdr(a);
      MDR_out = 1'b1; Y_rd = 1'b1; tick(); clear_ctrl();
      load_mdr(b);
      MDR_out = 1'b1; op_sel = op; Zlo_rd = 1'b1; tick(); clear_ctrl();
      check_eq({tag, "_lo"}, Zlo_view, elo);
      Zhi_out = 1'b1; #1;
      check_eq({tag, "_hi"}, BusMuxOut, ehi);
      clear_ctrl();
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_r3"},  r3_view,  32'd0);
      check_eq({tag, "_r4"},  r4_view,  32'd0);
      check_eq({tag, "_r7"},  r7_view,  32'd0);
      check_eq({tag, "_y"},   Y_view,   32'd0);
      check_eq({tag, "_zlo"}, Zlo_view, 32'd0);
      check_eq({tag, "_mdr"}, MDR_view, 32'd0);
      check_eq({tag, "_pc"},  PC_view,  32'd0);
   endtask

   initial begin
      logic [4:0] ops [14];
      ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd0};
      clear_ctrl();
      Mdatain = 32'd0;
      clr = 1'b1;
      model_clear();

      // Reset with enables asserted
      #2 clr = 1'b0;
      R_rd = 16'hFFFF; MDR_rd = 1'b1; Read = 1'b1; Mdatain = 32'h55; PC_rd = 1'b1; Y_rd = 1'b1; IncPC = 1'b1;
      #1 check_all_zero("rst_async");
      @(posedge clk); #1;
      check_all_zero("rst_held");
      clear_ctrl();
      clr = 1'b1;

      // Register loads
      clear_ctrl(); Mdatain = 32'h17; Read = 1'b1; MDR_rd = 1'b1; tick();
      check_eq("mdr_load", MDR_view, 32'h17);
      check_eq("data_view_load", Data_view, 32'h17);
      clear_ctrl();
      mdr_to_reg(3);
      check_eq("r3_load", r3_view, 32'h17);
      load_mdr(32'h14); mdr_to_reg(4);
      check_eq("r4_load", r4_view, 32'h14);
      load_mdr(32'h50); mdr_to_reg(7);
      check_eq("r7_load", r7_view, 32'h50);

      // Add sequence
      load_mdr(32'h19A38000);
      MDR_out = 1'b1; IR_rd = 1'b1; tick(); clear_ctrl();
      C_out = 1'b1; #1;
      check_eq("c_ext_pos", BusMuxOut, 32'h00038000);
      clear_ctrl();
      R_wrt[3] = 1'b1; Y_rd = 1'b1; tick(); clear_ctrl();
      check_eq("add_y", Y_view, 32'h17);
      R_wrt[7] = 1'b1; op_sel = 5'b00011; Zlo_rd = 1'b1; tick(); clear_ctrl();
      check_eq("add_zlo", Zlo_view, 32'h67);
      Zlo_out = 1'b1; R_rd[4] = 1'b1; tick(); clear_ctrl();
      check_eq("add_r4", r4_view, 32'h67);

      // PC behaviour
      load_mdr(32'd7);
      MDR_out = 1'b1; PC_rd = 1'b1; tick(); clear_ctrl();
      check_eq("pc_load", PC_view, 32'd7);
      IncPC = 1'b1; tick(); clear_ctrl();
      check_eq("pc_inc", PC_view, 32'd8);
      load_mdr(32'hFFFFFFFF);
      MDR_out = 1'b1; PC_rd = 1'b1; tick(); clear_ctrl();
      IncPC = 1'b1; tick(); clear_ctrl();
      check_eq("pc_wrap", PC_view, 32'd0);
      load_mdr(32'h1234);
      MDR_out = 1'b1; PC_rd = 1'b1; IncPC = 1'b1; tick(); clear_ctrl();
      check_eq("pc_rd_wins", PC_view, 32'h1234);

      // ALU corners
      alu_check("sub",   32'h14,       32'h17, 5'b00100, 32'h0,        32'hFFFFFFFD);
      alu_check("mul",   32'hFFFFFFFE, 32'd3,  5'b01111, 32'hFFFFFFFF, 32'hFFFFFFFA);
      alu_check("div",   32'd7,        32'd2,  5'b10000, 32'd1,        32'd3);
      alu_check("div0",  32'd7,        32'd0,  5'b10000, 32'd0,        32'd0);
      alu_check("shra",  32'h80000000, 32'd4,  5'b01010, 32'd0,        32'hF8000000);

      // Bus priority
      R_wrt[3] = 1'b1; MDR_out = 1'b1; #1;
      check_eq("prio_r3_mdr", BusMuxOut, 32'h17);
      clear_ctrl(); #1;
      check_eq("bus_idle", BusMuxOut, 32'd0);
      load_mdr(32'h00041234);
      MDR_out = 1'b1; IR_rd = 1'b1; tick(); clear_ctrl();
      C_out = 1'b1; #1;
      check_eq("c_ext_neg", BusMuxOut, 32'hFFFC1234);
      clear_ctrl();

      // Randomized transfers against the model
      for (int it = 0; it < 400; it++) begin
         logic [31:0] b;
         clear_ctrl();
         if (it == 200) begin
            clr = 1'b0; R_rd = 16'hFFFF; Y_rd = 1'b1; PC_rd = 1'b1;
            #1 check_all_zero("rst_mid");
            model_clear();
            @(posedge clk); #1;
            check_all_zero("rst_mid_held");
            clear_ctrl();
            clr = 1'b1;
         end
         case ($urandom_range(0, 3))
            0: R_wrt = 16'd0;
            1: R_wrt = 16'd1 << $urandom_range(0, 15);
            default: R_wrt = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
         endcase
         HI_out  = ($urandom_range(0, 9) == 0);
         LO_out  = ($urandom_range(0, 9) == 0);
         Zhi_out = ($urandom_range(0, 5) == 0);
         Zlo_out = ($urandom_range(0, 5) == 0);
         PC_out  = ($urandom_range(0, 7) == 0);
         MDR_out = ($urandom_range(0, 3) == 0);
         MAR_out = ($urandom_range(0, 7) == 0);
         In_out  = ($urandom_range(0, 9) == 0);
         C_out   = ($urandom_range(0, 5) == 0);
         R_rd    = 16'($urandom & $urandom & $urandom);
         MAR_rd  = ($urandom_range(0, 3) == 0);
         Zlo_rd  = ($urandom_range(0, 1) == 0);
         PC_rd   = ($urandom_range(0, 5) == 0);
         MDR_rd  = ($urandom_range(0, 2) == 0);
         IR_rd   = ($urandom_range(0, 4) == 0);
         Y_rd    = ($urandom_range(0, 2) == 0);
         IncPC   = ($urandom_range(0, 2) == 0);
         Read    = ($urandom_range(0, 1) == 0);
         op_sel  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : ops[$urandom_range(0, 13)];
         Mdatain = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         b = m_bus();
         // Signed overflow of the most-negative value by -1 has no defined result
         if (op_sel == 5'd16 && m_y == 32'h80000000 && b == 32'hFFFFFFFF) op_sel = 5'd3;
         tick();
      end
      clear_ctrl();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
